// File: rtl/m6502_fetch_unit.sv
// Instruction fetch for a 6502-style core: boots through the reset vector, then streams
// opcode and operand bytes over a single-outstanding read port into instruction records.
module m6502_fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_opcode,
    output logic [15:0] out_operand,
    output logic [1:0]  out_len,
    output logic [15:0] out_pc
);

    typedef enum logic [2:0] {
        StVecLo,
        StVecHi,
        StOpcode,
        StOprLo,
        StOprHi,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic        run_q;
    logic        wait_q, wait_d;
    logic        drop_q, drop_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [1:0]  len_q, len_d;
    logic [15:0] opc_pc_q, opc_pc_d;
    logic        issue;
    logic [1:0]  rd_len;

    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        unique case (op[3:0])
            4'h0: begin
                if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
                else if (op == 8'h20) len = 2'd3;
                else len = 2'd2;
            end
            4'h1, 4'h4, 4'h5, 4'h6: len = 2'd2;
            4'h2: len = (op == 8'hA2) ? 2'd2 : 2'd1;
            4'h9: len = op[4] ? 2'd3 : 2'd2;
            4'hC, 4'hD, 4'hE: len = 2'd3;
            default: len = 2'd1;
        endcase
        return len;
    endfunction

    assign rd_len = op_len(mem_rdata);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        drop_d    = drop_q;
        pc_d      = pc_q;
        vec_lo_d  = vec_lo_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        len_d     = len_q;
        opc_pc_d  = opc_pc_q;
        mem_req   = 1'b0;
        mem_addr  = 16'h0000;

        // wait_q marks the response cycle, during which no new request may issue
        issue = run_q && !wait_q && (state_q != StHold);
        if (issue) begin
            mem_req = 1'b1;
            if (state_q == StVecLo) mem_addr = RESET_VECTOR;
            else if (state_q == StVecHi) mem_addr = RESET_VECTOR + 16'd1;
            else mem_addr = pc_q;
            if (mem_gnt) wait_d = 1'b1;
        end

        if (wait_q) begin
            wait_d = 1'b0;
            drop_d = 1'b0;
            if (!drop_q) begin
                unique case (state_q)
                    StVecLo: begin
                        vec_lo_d = mem_rdata;
                        state_d  = StVecHi;
                    end
                    StVecHi: begin
                        pc_d    = {mem_rdata, vec_lo_q};
                        state_d = StOpcode;
                    end
                    StOpcode: begin
                        opcode_d  = mem_rdata;
                        opc_pc_d  = pc_q;
                        pc_d      = pc_q + 16'd1;
                        operand_d = 16'h0000;
                        len_d     = rd_len;
                        state_d   = (rd_len == 2'd1) ? StHold : StOprLo;
                    end
                    StOprLo: begin
                        operand_d[7:0] = mem_rdata;
                        pc_d           = pc_q + 16'd1;
                        state_d        = (len_q == 2'd3) ? StOprHi : StHold;
                    end
                    StOprHi: begin
                        operand_d[15:8] = mem_rdata;
                        pc_d            = pc_q + 16'd1;
                        state_d         = StHold;
                    end
                    default: ;
                endcase
            end
        end

        if (state_q == StHold && out_ready) state_d = StOpcode;

        // A read granted in the redirect cycle still returns data next cycle; drop it
        if (redirect_valid) begin
            state_d   = StOpcode;
            pc_d      = redirect_pc;
            operand_d = 16'h0000;
            wait_d    = mem_req && mem_gnt;
            drop_d    = mem_req && mem_gnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StVecLo;
            run_q     <= 1'b0;
            wait_q    <= 1'b0;
            drop_q    <= 1'b0;
            pc_q      <= 16'h0000;
            vec_lo_q  <= 8'h00;
            opcode_q  <= 8'h00;
            operand_q <= 16'h0000;
            len_q     <= 2'd0;
            opc_pc_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            wait_q    <= wait_d;
            drop_q    <= drop_d;
            pc_q      <= pc_d;
            vec_lo_q  <= vec_lo_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            len_q     <= len_d;
            opc_pc_q  <= opc_pc_d;
        end
    end

    assign out_valid   = (state_q == StHold);
    assign out_opcode  = opcode_q;
    assign out_operand = operand_q;
    assign out_len     = len_q;
    assign out_pc      = opc_pc_q;

endmodule

// File: tb/tb_m6502_fetch_unit.sv
// Bench for m6502_fetch_unit: a memory responder, a stream-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_m6502_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic [7:0]  mem_rdata = 8'hEE;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [15:0] out_operand;
    logic [1:0]  out_len;
    logic [15:0] out_pc;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    logic        stall_mode = 1'b0;
    int          gcnt = 0;

    // Instruction length by low nibble; nibble 0/2/9 exceptions handled in ref_len
    int base_len [16] = '{2, 2, 1, 1, 2, 2, 2, 1, 1, 2, 1, 1, 3, 3, 3, 1};

    m6502_fetch_unit #(.RESET_VECTOR(16'hFFFC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_operand   (out_operand),
        .out_len       (out_len),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int ref_len(input logic [7:0] op);
        int lo;
        int hi;
        lo = int'(op) % 16;
        hi = int'(op) / 16;
        if (lo == 9) return (hi % 2 == 1) ? 3 : 2;
        if (op == 8'h20) return 3;
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
        if (op == 8'hA2) return 2;
        return base_len[lo];
    endfunction

    // Memory: data for a grant appears in the following cycle only
    logic        acc;
    logic [15:0] acc_addr;
    always @(negedge clk) begin
        acc      = reset_n && mem_req && mem_gnt;
        acc_addr = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        mem_rdata = acc ? mem[acc_addr] : 8'hEE;
    end
    always @(posedge clk) begin
        #1;
        gcnt++;
        mem_gnt = !(stall_mode && (gcnt % 3 == 0));
    end

    // Reference model: requests walk sequential addresses, records tile memory by length
    logic [15:0] m_req, m_pc, p_addr, a1, a2, eoperand;
    logic [7:0]  vlo, eop;
    int          vec_left, eln;
    logic        p_grant, p_stall, p_hold;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_req", mem_req, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_rec", {out_opcode, out_len, out_pc}, 0);
            chk("rst_operand", out_operand, 0);
            m_req = 16'hFFFC; m_pc = 16'h0000; vec_left = 2;
            p_grant = 1'b0; p_stall = 1'b0; p_hold = 1'b0;
        end else begin
            if (p_grant) chk("req_in_resp_cycle", mem_req, 0);
            if (p_stall) begin
                chk("stall_req_held", mem_req, 1);
                chk("stall_addr_stable", mem_addr, p_addr);
            end
            if (p_hold) chk("valid_held", out_valid, 1);
            if (out_valid) chk("req_while_held", mem_req, 0);
            if (mem_req && mem_gnt) begin
                chk("req_addr", mem_addr, m_req);
                if (vec_left == 2) begin
                    vlo = mem[m_req]; m_req = m_req + 16'd1; vec_left = 1;
                end else if (vec_left == 1) begin
                    m_req = {mem[m_req], vlo}; m_pc = m_req; vec_left = 0;
                end else begin
                    m_req = m_req + 16'd1;
                end
            end
            if (out_valid) begin
                chk("valid_after_vector", vec_left, 0);
                eop = mem[m_pc];
                eln = ref_len(eop);
                a1 = m_pc + 16'd1;
                a2 = m_pc + 16'd2;
                eoperand = (eln == 1) ? 16'h0000 :
                           (eln == 2) ? {8'h00, mem[a1]} : {mem[a2], mem[a1]};
                chk("rec_opcode", out_opcode, eop);
                chk("rec_len", out_len, eln);
                chk("rec_pc", out_pc, m_pc);
                chk("rec_operand", out_operand, eoperand);
                if (out_ready && !redirect_valid) m_pc = m_pc + 16'(eln);
            end
            p_grant = mem_req && mem_gnt;
            p_stall = mem_req && !mem_gnt && !redirect_valid;
            p_addr  = mem_addr;
            p_hold  = out_valid && !out_ready && !redirect_valid;
            if (redirect_valid) begin
                m_req = redirect_pc; m_pc = redirect_pc; vec_left = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk(name, 0, 1);
    endtask

    // Accept the held record, then expect the next opcode request the following cycle
    task automatic accept_next(input string name, input logic [15:0] exp_addr);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_req"}, mem_req, 1);
        chk({name, "_addr"}, mem_addr, exp_addr);
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    logic [7:0] prog [32] = '{8'hAD, 8'h34, 8'h12, 8'h00, 8'h20, 8'h01, 8'h02, 8'h40,
                              8'h60, 8'hA2, 8'h11, 8'h02, 8'h09, 8'h22, 8'h19, 8'h33,
                              8'h44, 8'h0C, 8'h55, 8'h66, 8'h1D, 8'h77, 8'h88, 8'h7E,
                              8'h99, 8'hAA, 8'hAA, 8'h13, 8'h91, 8'hBB, 8'h81, 8'hCC};

    initial begin
        int c0, c1, n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        for (int i = 0; i < 32; i++) mem[16'h8001 + 16'(i)] = prog[i];
        mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h77;
        mem[16'hD000] = 8'h4C; mem[16'hD001] = 8'h34; mem[16'hD002] = 8'h12;
        mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h05;

        reset_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        repeat (3) @(negedge clk);

        // Boot: first request only after the first edge following reset release
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("req_before_first_edge", mem_req, 0);
        @(negedge clk);
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 16'hFFFC);
        c0 = -100; c1 = -50;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(negedge clk);
            if (mem_req && mem_gnt && mem_addr == 16'h8000) c0 = i;
            if (out_valid) c1 = i;
        end
        chk("min_latency", c1 - c0, 2);
        chk("boot_opcode", out_opcode, 8'hEA);
        chk("boot_len", out_len, 1);
        chk("boot_pc", out_pc, 16'h8000);
        chk("boot_operand", out_operand, 16'h0000);

        // Backpressure for five cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_no_req", mem_req, 0);
            chk("bp_opcode", out_opcode, 8'hEA);
        end
        accept_next("bp_accept", 16'h8001);

        wait_valid("wait_3byte");
        chk("abs_opcode", out_opcode, 8'hAD);
        chk("abs_operand", out_operand, 16'h1234);
        chk("abs_len", out_len, 3);
        chk("abs_pc", out_pc, 16'h8001);
        accept_next("abs_accept", 16'h8004);

        // Mixed-length stream under grant stalls, checked by the model
        stall_mode = 1'b1;
        step();
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 600 && n < 17; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
        end
        chk("stream_records", n, 17);
        step();
        out_ready = 1'b0;
        stall_mode = 1'b0;

        // Redirect while held, with out_ready high: record dropped, minimum latency
        wait_valid("wait_before_redirect");
        mem[16'h9000] = 8'hEA;
        step();
        redirect_valid = 1'b1; redirect_pc = 16'h9000; out_ready = 1'b1;
        step();
        redirect_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("redir_valid_low", out_valid, 0);
        chk("redir_req", mem_req, 1);
        chk("redir_addr", mem_addr, 16'h9000);
        @(negedge clk);
        chk("redir_resp_no_req", mem_req, 0);
        chk("redir_resp_valid", out_valid, 0);
        @(negedge clk);
        chk("redir_rec_valid", out_valid, 1);
        chk("redir_rec_pc", out_pc, 16'h9000);

        // Redirect in the response cycle of an opcode grant
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        redirect_to(16'hC000);
        @(negedge clk);
        chk("rsp_redir_req", mem_req, 1);
        chk("rsp_redir_addr", mem_addr, 16'hC000);
        wait_valid("wait_c000");
        chk("c000_opcode", out_opcode, 8'hA9);
        chk("c000_operand", out_operand, 16'h0077);
        chk("c000_len", out_len, 2);
        chk("c000_pc", out_pc, 16'hC000);

        // Redirect in the grant cycle itself: the late response must be dropped
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'hD000;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("drop_cycle_no_req", mem_req, 0);
        @(negedge clk);
        chk("drop_next_req", mem_req, 1);
        chk("drop_next_addr", mem_addr, 16'hD000);
        wait_valid("wait_d000");
        chk("d000_opcode", out_opcode, 8'h4C);
        chk("d000_operand", out_operand, 16'h1234);
        chk("d000_len", out_len, 3);

        // PC wraps from FFFF to 0000
        redirect_to(16'hFFFF);
        wait_valid("wait_wrap");
        chk("wrap_opcode", out_opcode, 8'hA9);
        chk("wrap_operand", out_operand, 16'h0005);
        chk("wrap_len", out_len, 2);
        chk("wrap_pc", out_pc, 16'hFFFF);
        accept_next("wrap_accept", 16'h0001);

        // Asynchronous reset while a record is held
        wait_valid("wait_before_reset");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_req", mem_req, 0);
        chk("async_opcode", out_opcode, 0);
        repeat (2) @(negedge clk);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("restart_addr", mem_addr, 16'hFFFC);
        wait_valid("wait_restart");
        chk("restart_opcode", out_opcode, 8'hEA);
        chk("restart_pc", out_pc, 16'h8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m6502_fetch_unit.md
M6502_FETCH_UNIT -- requirements
Module: m6502_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'hFFFC, address of reset-vector low byte.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_req  output  1  read request.
REQ-005 SHALL have port mem_addr  output  16  read address; valid while mem_req high.
REQ-006 SHALL have port mem_gnt  input  1  request accepted when mem_req && mem_gnt.
REQ-007 SHALL have port mem_rdata  input  8  read data; valid exactly one cycle after acceptance.
REQ-008 SHALL have port redirect_valid  input  1  flush and restart fetch at redirect_pc.
REQ-009 SHALL have port redirect_pc  input  16  new program counter.
REQ-010 SHALL have port out_valid  output  1  instruction record available.
REQ-011 SHALL have port out_ready  input  1  downstream decoder accepts record.
REQ-012 SHALL have port out_opcode  output  8  raw opcode byte.
REQ-013 SHALL have port out_operand  output  16  operand bytes, {hi, lo}; unused bytes zero.
REQ-014 SHALL have port out_len  output  2  instruction length in bytes, 1..3.
REQ-015 SHALL have port out_pc  output  16  address of the opcode byte.

Function
REQ-016 SHALL implement states VEC_LO, VEC_HI, OPCODE, OPR_LO, OPR_HI, HOLD.
REQ-017 SHALL issue at most one outstanding read; no new mem_req during the response cycle.
REQ-018 VEC_LO SHALL read RESET_VECTOR; VEC_HI SHALL read RESET_VECTOR+1; PC <= {hi, lo}; next OPCODE.
REQ-019 OPCODE SHALL read PC, latch opcode, out_pc <= PC, PC <= PC+1, compute length per REQ-020.
REQ-020 Length rule by low nibble n / high nibble h: n=0: 00,40,60 ->1, 20 ->3, others ->2; n=1 ->2; n=2: A2 ->2, else 1; n=4,5,6 ->2; n=8,A ->1; n=9: h even ->2, h odd ->3; n=C,D,E ->3; n=3,7,B,F ->1.
REQ-021 Length 1 -> HOLD; length 2 or 3 -> OPR_LO.
REQ-022 OPR_LO SHALL read PC into operand[7:0], PC <= PC+1; length 3 -> OPR_HI, else HOLD.
REQ-023 OPR_HI SHALL read PC into operand[15:8], PC <= PC+1, -> HOLD.
REQ-024 PC SHALL wrap FFFF -> 0000 modulo 2^16; no other effect.
REQ-025 HOLD SHALL assert out_valid; record stable until out_valid && out_ready.
REQ-026 On acceptance SHALL go to OPCODE; mem_req for next opcode no earlier than the following cycle.
REQ-027 mem_req held while mem_gnt low; mem_addr stable until granted.
REQ-028 Minimum latency: 1-byte instruction, gnt always high: opcode request cycle 0, out_valid cycle 2.
REQ-029 redirect_valid SHALL have priority over every state and over out_ready: PC <= redirect_pc, out_valid low next cycle, operand cleared, -> OPCODE.
REQ-030 Redirect during a vector fetch SHALL abandon the vector fetch.
REQ-031 Read response due in the cycle after redirect SHALL be discarded (one-cycle drop flag); first request to redirect_pc no earlier than that cycle.
REQ-032 Redirect while held SHALL discard the held record regardless of out_ready.

Reset
REQ-033 reset_n low SHALL immediately force: mem_req=0, mem_addr=0, out_valid=0, out_opcode=0, out_operand=0, out_len=0, out_pc=0, PC=0, drop flag=0, state=VEC_LO.
REQ-034 Reset mid-transaction SHALL abandon all state; response to a pre-reset request is ignored.
REQ-035 First mem_req SHALL assert on the first rising edge after reset_n deasserts, at RESET_VECTOR.

Verification
REQ-036 Reset vector: mem[FFFC]=00, mem[FFFD]=80, mem[8000]=EA, gnt=1 -> reads FFFC, FFFD, 8000; record opcode EA, len 1, pc 8000, operand 0000.
REQ-037 Three-byte: mem[8000..8002]=AD 34 12, out_ready=1 -> opcode AD, operand 1234, len 3, pc 8000; next fetch at 8003.
REQ-038 Backpressure: out_ready=0 for 5 cycles after out_valid -> record constant, mem_req=0; accepted on ready cycle; next fetch starts following cycle.
REQ-039 Redirect: redirect_valid with redirect_pc=C000 in cycle after an opcode request grant -> that response discarded; next request C000; no record from old stream.
REQ-040 Wrap: PC=FFFF, mem[FFFF]=A9, mem[0000]=05 -> opcode A9, operand 0005, len 2, next fetch 0001.
REQ-041 Async reset while held with out_valid=1 -> out_valid 0 without clock edge; restart at RESET_VECTOR.
